// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI AR arbiter: payload width function and FSM state enum.
package axi_arb_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } arb_state_e;

    // AR payload is {cache,prot,lock,burst,size,len,qos,region,addr,user}; fixed fields sum to 29.
    function automatic int unsigned ar_width(input int unsigned addr_w, input int unsigned user_w);
        return 29 + addr_w + user_w;
    endfunction

endpackage

// File: rtl/rr_lzc_sel.sv
// Round-robin first-one selector: first set request at or after the pointer, wrapping.
module rr_lzc_sel #(
    parameter int unsigned N_REQ = 2,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    always_comb begin
        int unsigned w_j;
        w_j     = 0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_j = (32'(i_ptr) + i) % N_REQ;
            if (!o_valid && i_req[w_j]) begin
                o_valid = 1'b1;
                o_idx   = w_j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/axi_ar_arbiter.sv
// Round-robin arbiter merging N AXI AR channels onto one master port.
// Define AXI_AR_ARB_LIMIT_EN to throttle issue on the in-flight read count.
module axi_ar_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned N_SLAVE         = 2,
    parameter int unsigned ID_WIDTH        = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned USER_WIDTH      = 1,
    parameter int unsigned MAX_OUTSTANDING = 8,
    localparam int unsigned AR_W  = ar_width(ADDR_WIDTH, USER_WIDTH),
    localparam int unsigned IDX_W = $clog2(N_SLAVE),
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [N_SLAVE-1:0]        slave_valid_i,
    input  logic [N_SLAVE*AR_W-1:0]   slave_ar_i,
    input  logic [N_SLAVE*ID_WIDTH-1:0] slave_id_i,
    output logic [N_SLAVE-1:0]        slave_ready_o,
    output logic                      master_valid_o,
    output logic [AR_W-1:0]           master_ar_o,
    output logic [ID_WIDTH+IDX_W-1:0] master_id_o,
    input  logic                      master_ready_i,
    input  logic                      rd_done_i,
    output logic [CNT_W-1:0]          outstanding_o
);

    arb_state_e       r_state, w_state_nxt;
    logic [IDX_W-1:0] r_gnt, w_gnt_nxt;
    logic [IDX_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_sel_valid;
    logic             w_gnt_valid;
    logic             w_hs;
    logic             w_can_issue;

    rr_lzc_sel #(
        .N_REQ (N_SLAVE)
    ) u_rr_lzc_sel (
        .i_req   (slave_valid_i),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_sel_idx),
        .o_valid (w_sel_valid)
    );

    assign w_gnt_valid = slave_valid_i[r_gnt];
    assign master_ar_o = slave_ar_i[int'(r_gnt)*AR_W +: AR_W];
    assign master_id_o = {r_gnt, slave_id_i[int'(r_gnt)*ID_WIDTH +: ID_WIDTH]};

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_rr_ptr_nxt   = r_rr_ptr;
        master_valid_o = 1'b0;
        slave_ready_o  = '0;
        w_hs           = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_sel_valid && w_can_issue) begin
                    w_state_nxt = StGrant;
                    w_gnt_nxt   = w_sel_idx;
                end
            end
            StGrant: begin
                master_valid_o       = w_gnt_valid;
                slave_ready_o[r_gnt] = master_ready_i;
                w_hs                 = w_gnt_valid && master_ready_i;
                if (w_hs) begin
                    w_state_nxt  = StIdle;
                    w_rr_ptr_nxt = (r_gnt == IDX_W'(N_SLAVE - 1)) ? '0 : r_gnt + IDX_W'(1);
                end else if (!w_gnt_valid) begin
                    // Requester withdrew valid: drop the grant without counting it.
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= StIdle;
            r_gnt    <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

`ifdef AXI_AR_ARB_LIMIT_EN
    logic [CNT_W-1:0] r_outstanding, w_outstanding_nxt;
    logic             w_dec;

    // A completion at zero is ignored so the count never underflows.
    assign w_dec       = rd_done_i && (r_outstanding != '0);
    assign w_can_issue = (r_outstanding < CNT_W'(MAX_OUTSTANDING));

    always_comb begin
        w_outstanding_nxt = r_outstanding;
        case ({w_hs, w_dec})
            2'b10:   w_outstanding_nxt = r_outstanding + CNT_W'(1);
            2'b01:   w_outstanding_nxt = r_outstanding - CNT_W'(1);
            default: w_outstanding_nxt = r_outstanding;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_outstanding <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
        end
    end

    assign outstanding_o = r_outstanding;
`else
    logic w_unused_rd_done;

    assign w_unused_rd_done = rd_done_i;
    assign w_can_issue      = 1'b1;
    assign outstanding_o    = '0;
`endif

endmodule

// File: tb/tb_axi_ar_arbiter.sv
// Directed self-checking bench for axi_ar_arbiter (N=2, MAX_OUTSTANDING=2).
module tb_axi_ar_arbiter;

    localparam int unsigned N    = 2;
    localparam int unsigned IDW  = 4;
    localparam int unsigned AW   = 32;
    localparam int unsigned UW   = 1;
    localparam int unsigned MAXO = 2;
    localparam int unsigned ARW  = 29 + AW + UW;
    localparam int unsigned MIDW = IDW + 1;
    localparam int unsigned CW   = 2;
`ifdef AXI_AR_ARB_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    localparam logic [ARW-1:0] AR0_VAL = 62'h0123_4567_89AB_CDEF;
    localparam logic [ARW-1:0] AR1_VAL = 62'h3EDC_BA98_7654_3210;
    localparam logic [IDW-1:0] ID0_VAL = 4'h3;
    localparam logic [IDW-1:0] ID1_VAL = 4'hA;

    logic            clk;
    logic            rst_ni;
    logic [N-1:0]    slave_valid_i;
    logic [ARW-1:0]  ar0, ar1;
    logic [N*ARW-1:0] slave_ar_i;
    logic [N*IDW-1:0] slave_id_i;
    logic [N-1:0]    slave_ready_o;
    logic            master_valid_o;
    logic [ARW-1:0]  master_ar_o;
    logic [MIDW-1:0] master_id_o;
    logic            master_ready_i;
    logic            rd_done_i;
    logic [CW-1:0]   outstanding_o;

    int n_checks;
    int n_fail;

    assign slave_ar_i = {ar1, ar0};
    assign slave_id_i = {ID1_VAL, ID0_VAL};

    axi_ar_arbiter #(
        .N_SLAVE         (N),
        .ID_WIDTH        (IDW),
        .ADDR_WIDTH      (AW),
        .USER_WIDTH      (UW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .slave_valid_i  (slave_valid_i),
        .slave_ar_i     (slave_ar_i),
        .slave_id_i     (slave_id_i),
        .slave_ready_o  (slave_ready_o),
        .master_valid_o (master_valid_o),
        .master_ar_o    (master_ar_o),
        .master_id_o    (master_id_o),
        .master_ready_i (master_ready_i),
        .rd_done_i      (rd_done_i),
        .outstanding_o  (outstanding_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        slave_valid_i = 2'b11;
        repeat (3) step();
        n_checks++;
        if (master_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", master_valid_o);
        end
        n_checks++;
        if (slave_ready_o !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready: got %b want 00", slave_ready_o);
        end
        n_checks++;
        if (outstanding_o !== 2'd0) begin
            n_fail++; $display("FAIL reset_outstanding: got %0d want 0", outstanding_o);
        end
        slave_valid_i = 2'b00;
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_underflow();
        rd_done_i = 1'b1;
        step();
        rd_done_i = 1'b0;
        n_checks++;
        if (outstanding_o !== 2'd0) begin
            n_fail++; $display("FAIL underflow: got %0d want 0", outstanding_o);
        end
        step();
    endtask

    task automatic test_alternate();
        logic           exp_port;
        logic [ARW-1:0] exp_ar;
        logic [IDW-1:0] exp_id;
        slave_valid_i  = 2'b11;
        master_ready_i = 1'b1;
        rd_done_i      = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_port = (k % 2) == 1;
            exp_ar   = exp_port ? AR1_VAL : AR0_VAL;
            exp_id   = exp_port ? ID1_VAL : ID0_VAL;
            step();
            n_checks++;
            if (master_valid_o !== 1'b1 || master_id_o !== {exp_port, exp_id}) begin
                n_fail++;
                $display("FAIL alt_grant%0d: got valid=%b id=%h want valid=1 id=%h",
                         k, master_valid_o, master_id_o, {exp_port, exp_id});
            end
            n_checks++;
            if (master_ar_o !== exp_ar) begin
                n_fail++; $display("FAIL alt_payload%0d: got %h want %h", k, master_ar_o, exp_ar);
            end
            step();
            n_checks++;
            if (master_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL alt_idle%0d: got %b want 0", k, master_valid_o);
            end
        end
        slave_valid_i = 2'b00;
        step();
        rd_done_i = 1'b0;
        n_checks++;
        if (outstanding_o !== 2'd0) begin
            n_fail++; $display("FAIL alt_drain: got %0d want 0", outstanding_o);
        end
    endtask

    task automatic test_hold();
        slave_valid_i  = 2'b10;
        master_ready_i = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (master_valid_o !== 1'b1 || master_ar_o !== AR1_VAL ||
                master_id_o !== {1'b1, ID1_VAL} || slave_ready_o !== 2'b00) begin
                n_fail++;
                $display("FAIL hold%0d: got valid=%b ar=%h id=%h rdy=%b want 1 %h %h 00",
                         i, master_valid_o, master_ar_o, master_id_o, slave_ready_o,
                         AR1_VAL, {1'b1, ID1_VAL});
            end
            slave_valid_i = 2'b11;
            ar0 = ~AR0_VAL;
            step();
        end
        ar0 = AR0_VAL;
        master_ready_i = 1'b1;
        #1;
        n_checks++;
        if (slave_ready_o !== 2'b10) begin
            n_fail++; $display("FAIL hold_ready: got %b want 10", slave_ready_o);
        end
        step();
        slave_valid_i = 2'b00;
        n_checks++;
        if (outstanding_o !== (LIMIT_EN ? 2'd1 : 2'd0)) begin
            n_fail++; $display("FAIL hold_count: got %0d want %0d", outstanding_o,
                               LIMIT_EN ? 1 : 0);
        end
    endtask

    task automatic test_hs_and_done();
        slave_valid_i = 2'b01;
        step();
        n_checks++;
        if (master_valid_o !== 1'b1 || master_id_o[MIDW-1] !== 1'b0) begin
            n_fail++; $display("FAIL hsdone_grant: got valid=%b id=%h want valid=1 port 0",
                               master_valid_o, master_id_o);
        end
        rd_done_i = 1'b1;
        step();
        rd_done_i = 1'b0;
        slave_valid_i = 2'b00;
        n_checks++;
        if (outstanding_o !== (LIMIT_EN ? 2'd1 : 2'd0)) begin
            n_fail++; $display("FAIL hsdone_count: got %0d want %0d", outstanding_o,
                               LIMIT_EN ? 1 : 0);
        end
        rd_done_i = 1'b1;
        step();
        rd_done_i = 1'b0;
        n_checks++;
        if (outstanding_o !== 2'd0) begin
            n_fail++; $display("FAIL hsdone_drain: got %0d want 0", outstanding_o);
        end
    endtask

    task automatic test_limit();
        int hs;
        hs = 0;
        slave_valid_i  = 2'b11;
        master_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (master_valid_o && master_ready_i) hs++;
        end
        n_checks++;
        if (hs !== (LIMIT_EN ? 2 : 4)) begin
            n_fail++; $display("FAIL limit_stall: got %0d handshakes want %0d", hs,
                               LIMIT_EN ? 2 : 4);
        end
        n_checks++;
        if (outstanding_o !== (LIMIT_EN ? 2'd2 : 2'd0)) begin
            n_fail++; $display("FAIL limit_count: got %0d want %0d", outstanding_o,
                               LIMIT_EN ? 2 : 0);
        end
        rd_done_i = 1'b1;
        step();
        rd_done_i = 1'b0;
        hs = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (master_valid_o && master_ready_i) hs++;
        end
        n_checks++;
        if (hs !== (LIMIT_EN ? 1 : 3)) begin
            n_fail++; $display("FAIL limit_resume: got %0d handshakes want %0d", hs,
                               LIMIT_EN ? 1 : 3);
        end
        slave_valid_i = 2'b00;
        rd_done_i = 1'b1;
        step();
        step();
        rd_done_i = 1'b0;
        n_checks++;
        if (outstanding_o !== 2'd0) begin
            n_fail++; $display("FAIL limit_drain: got %0d want 0", outstanding_o);
        end
    endtask

    task automatic test_drop();
        slave_valid_i  = 2'b01;
        master_ready_i = 1'b0;
        step();
        slave_valid_i = 2'b00;
        step();
        n_checks++;
        if (master_valid_o !== 1'b0 || outstanding_o !== 2'd0) begin
            n_fail++; $display("FAIL drop_idle: got valid=%b cnt=%0d want 0 0",
                               master_valid_o, outstanding_o);
        end
        slave_valid_i  = 2'b10;
        master_ready_i = 1'b1;
        step();
        n_checks++;
        if (master_valid_o !== 1'b1 || master_id_o !== {1'b1, ID1_VAL}) begin
            n_fail++; $display("FAIL drop_regrant: got valid=%b id=%h want 1 %h",
                               master_valid_o, master_id_o, {1'b1, ID1_VAL});
        end
        step();
        slave_valid_i = 2'b00;
        rd_done_i = 1'b1;
        step();
        rd_done_i = 1'b0;
    endtask

    task automatic test_reset_mid_grant();
        slave_valid_i  = 2'b01;
        master_ready_i = 1'b1;
        step();
        step();
        slave_valid_i  = 2'b10;
        master_ready_i = 1'b0;
        step();
        n_checks++;
        if (master_valid_o !== 1'b1 || master_id_o[MIDW-1] !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre: got valid=%b id=%h want valid=1 port 1",
                               master_valid_o, master_id_o);
        end
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (master_valid_o !== 1'b0 || slave_ready_o !== 2'b00 || outstanding_o !== 2'd0) begin
            n_fail++; $display("FAIL rstmid_async: got valid=%b rdy=%b cnt=%0d want 0 00 0",
                               master_valid_o, slave_ready_o, outstanding_o);
        end
        slave_valid_i  = 2'b11;
        master_ready_i = 1'b1;
        #1;
        rst_ni = 1'b1;
        step();
        n_checks++;
        if (master_valid_o !== 1'b1 || master_id_o !== {1'b0, ID0_VAL}) begin
            n_fail++; $display("FAIL rstmid_next: got valid=%b id=%h want 1 %h",
                               master_valid_o, master_id_o, {1'b0, ID0_VAL});
        end
        step();
        slave_valid_i = 2'b00;
        step();
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_ni         = 1'b0;
        slave_valid_i  = '0;
        master_ready_i = 1'b0;
        rd_done_i      = 1'b0;
        ar0            = AR0_VAL;
        ar1            = AR1_VAL;
        test_reset();
        test_underflow();
        test_alternate();
        test_hold();
        test_hs_and_done();
        test_limit();
        test_drop();
        test_reset_mid_grant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
